// File: rtl/comm_pkg.sv
// Shared Hamming(7,4) definitions for the channel encoder and the downstream decoder.
// Info bit d[0] is always the first bit received on the serial stream.
package comm_pkg;

  localparam int HAM_K = 4;
  localparam int HAM_N = 7;

  typedef logic [HAM_K-1:0] nibble_t;
  typedef logic [HAM_N-1:0] codeword_t;

  // Returns {p1, p2, p3} for the info nibble d.
  function automatic logic [2:0] ham74_parity(input nibble_t d);
    return {d[0] ^ d[1] ^ d[3],
            d[0] ^ d[2] ^ d[3],
            d[1] ^ d[2] ^ d[3]};
  endfunction

endpackage

// File: rtl/hamming74_enc.sv
// Combinational Hamming(7,4) encoder.
// Output is Hamming positions 1..7, MSB first: {p1, p2, d0, p3, d1, d2, d3}.
module hamming74_enc
  import comm_pkg::*;
(
  input  nibble_t   data,
  output codeword_t code
);

  logic [2:0] par;

  always_comb begin
    par  = ham74_parity(data);
    code = {par[2], par[1], data[0], par[0], data[1], data[2], data[3]};
  end

endmodule

// File: rtl/hamming74_framer.sv
// Serial info bits -> Hamming(7,4) codewords -> N_CW-codeword parallel frame.
// Codeword k (first received is k=0) lands in data_out[FRAME_W-1-7k -: 7].
module hamming74_framer
  import comm_pkg::*;
#(
  parameter  int N_CW    = 5,
  localparam int FRAME_W = HAM_N * N_CW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               din,
  input  logic               flush,
  output logic               en_out,
  output logic [FRAME_W-1:0] data_out,
  output logic [4:0]         bit_cnt
);

  localparam int              CW_W     = (N_CW > 1) ? $clog2(N_CW) : 1;
  localparam logic [CW_W-1:0] CW_LAST  = CW_W'(N_CW - 1);
  localparam logic [1:0]      NIB_LAST = 2'(HAM_K - 1);

  logic [1:0]         nib_cnt_q, nib_cnt_d;
  logic [CW_W-1:0]    cw_cnt_q, cw_cnt_d;
  nibble_t            nib_q, nib_d;
  logic [FRAME_W-1:0] acc_q, acc_d;
  logic [FRAME_W-1:0] data_out_q, data_out_d;
  logic               en_out_q, en_out_d;

  nibble_t            nib_cur;
  codeword_t          cw_cur;
  logic [FRAME_W-1:0] acc_with_cw;
  logic               nib_done;
  logic               frame_done;
  logic               flush_go;
  logic               emit;

  // Current nibble including this cycle's bit; unfilled positions stay zero,
  // which is exactly the padding a flush needs.
  always_comb begin
    nib_cur = nib_q;
    if (en) begin
      nib_cur[nib_cnt_q] = din;
    end
  end

  hamming74_enc u_enc (
    .data (nib_cur),
    .code (cw_cur)
  );

  always_comb begin
    acc_with_cw = acc_q;
    for (int k = 0; k < N_CW; k++) begin
      if (k == int'(cw_cnt_q)) begin
        acc_with_cw[FRAME_W-1-HAM_N*k -: HAM_N] = cw_cur;
      end
    end
  end

  assign nib_done   = en && (nib_cnt_q == NIB_LAST);
  assign frame_done = nib_done && (cw_cnt_q == CW_LAST);
  assign flush_go   = flush && (en || (nib_cnt_q != 2'd0) || (cw_cnt_q != '0));
  assign emit       = frame_done || flush_go;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    nib_cnt_d  = nib_cnt_q;
    cw_cnt_d   = cw_cnt_q;
    nib_d      = nib_q;
    acc_d      = acc_q;
    data_out_d = data_out_q;
    en_out_d   = 1'b0;

    if (emit) begin
      data_out_d = acc_with_cw;
      en_out_d   = 1'b1;
      acc_d      = '0;
      nib_d      = '0;
      nib_cnt_d  = 2'd0;
      cw_cnt_d   = '0;
    end else if (en) begin
      if (nib_done) begin
        acc_d     = acc_with_cw;
        nib_d     = '0;
        nib_cnt_d = 2'd0;
        cw_cnt_d  = cw_cnt_q + CW_W'(1);
      end else begin
        nib_d     = nib_cur;
        nib_cnt_d = nib_cnt_q + 2'd1;
      end
    end
  end

  // NOTE: state updates use non-blocking assignments; rst is only seen on a clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      nib_cnt_q  <= 2'd0;
      cw_cnt_q   <= '0;
      nib_q      <= '0;
      acc_q      <= '0;
      data_out_q <= '0;
      en_out_q   <= 1'b0;
    end else begin
      nib_cnt_q  <= nib_cnt_d;
      cw_cnt_q   <= cw_cnt_d;
      nib_q      <= nib_d;
      acc_q      <= acc_d;
      data_out_q <= data_out_d;
      en_out_q   <= en_out_d;
    end
  end

  assign en_out   = en_out_q;
  assign data_out = data_out_q;
  assign bit_cnt  = 5'({cw_cnt_q, 2'b00}) + 5'(nib_cnt_q);

endmodule
